seq_mult: RTL and testbench
===========================

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; the product width is 2*WIDTH (16 at default).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  multiplicand; captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  multiplier; captured on the accepting edge.
REQ-007 Port: busy  output  1  high while a multiply is in progress.
REQ-008 Port: done  output  1  one-cycle pulse marking the cycle in which a new P is first visible.
REQ-009 Port: P  output  2*WIDTH  registered product, driven to the downstream accumulator.

Function
REQ-010 The block SHALL implement an FSM with two states: IDLE and RUN.
REQ-011 IDLE with start=1 at edge k SHALL capture a and b into internal registers, clear the partial sum, clear the step counter, and move to RUN.
REQ-012 IDLE with start=0 SHALL hold all state.
REQ-013 In RUN, each edge SHALL perform one shift-add step: if the current multiplier LSB is 1, add the shifted multiplicand to the partial sum; then shift the multiplier right and the multiplicand left by 1; then increment the counter.
REQ-014 The partial sum and shifted multiplicand SHALL be 2*WIDTH bits wide.
REQ-015 No step SHALL overflow, because the product of two WIDTH-bit values fits in 2*WIDTH bits.
REQ-016 On edge k+WIDTH (the edge performing the last step), P SHALL load the final product, done SHALL go high for exactly one cycle, and the state SHALL return to IDLE.
REQ-017 busy SHALL be high in the cycles after edges k+1 through k+WIDTH-1 and low otherwise; at WIDTH=8 it is high for 7 cycles.
REQ-018 The latency from the accepting edge to done high SHALL be WIDTH cycles.
REQ-019 start during RUN SHALL be ignored, and a and b changes during RUN SHALL NOT affect the result.
REQ-020 start high in the cycle where done is high SHALL be accepted, giving back-to-back throughput of one product per WIDTH+1 cycles; P and done behave as in REQ-016 for each product.
REQ-021 P SHALL change only on a done edge and SHALL otherwise hold its value, so the downstream accumulator sees exactly one P update per product.
REQ-022 A result identical to the previous P SHALL still pulse done.
REQ-023 Early termination is not permitted: zero operands still take WIDTH cycles.

Reset
REQ-024 rst=1 SHALL asynchronously force state=IDLE, busy=0, done=0, P=0, and clear all internal registers and the counter.
REQ-025 rst asserted mid-RUN SHALL abort the operation with no done pulse, and the first start after rst deasserts SHALL begin a fresh operation.

Configuration
REQ-026 With macro SEQ_MULT_SIGNED_EN defined, a and b SHALL be two's complement: magnitudes are multiplied per REQ-013, and the final result is negated on the last step when sign(a) XOR sign(b) is 1, with the same latency.
REQ-027 With SEQ_MULT_SIGNED_EN defined, the most negative operand value SHALL be handled correctly, e.g. -128*-128=16384.
REQ-028 Without SEQ_MULT_SIGNED_EN, a and b SHALL be unsigned and no sign logic is present.

Verification
REQ-029 Basic multiply: rst pulse, then start=1 with a=3, b=5 for one cycle -> busy high, done pulse exactly 8 cycles after acceptance, P=0x000F held afterwards.
REQ-030 Unsigned maximum: a=255, b=255 -> P=0xFE01 (65025).
REQ-031 Zero and repeat: a=0, b=0xAB -> P=0x0000 after 8 cycles; then a repeat 0*7 -> done pulses again while P stays 0.
REQ-032 Start while busy: start a=2, b=3; during RUN drive start=1, a=9, b=9 -> exactly one done, P=6; then a back-to-back start in the done cycle with a=4, b=4 -> P=16 nine cycles after the first done.
REQ-033 Reset mid-operation: assert rst 4 cycles into a=10, b=10 -> P=0, no done, busy=0; a new start with a=1, b=1 -> P=1.
REQ-034 Signed build: with SEQ_MULT_SIGNED_EN, a=-3 (0xFD), b=5 -> P=0xFFF1; a=-128, b=-128 -> P=0x4000.

Source files
------------

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one partial-product step per clock, WIDTH steps per product.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands (sign-magnitude multiply, negate on last step).
module seq_mult #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] P
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam int CW = $clog2(WIDTH + 1);

   state_t             state, state_nx;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] psum;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;

   logic               accept;
   logic               last;
   logic [2*WIDTH-1:0] psum_nx;
   logic [2*WIDTH-1:0] result;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

`ifdef SEQ_MULT_SIGNED_EN
   logic neg;

   // Magnitude of the most negative value wraps to itself, which reads correctly as unsigned.
   always_comb begin
      a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
      b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         neg <= 1'b0;
      else if (accept)
         neg <= a[WIDTH-1] ^ b[WIDTH-1];
   end

   assign result = neg ? (~psum_nx + (2*WIDTH)'(1)) : psum_nx;
`else
   assign a_mag  = a;
   assign b_mag  = b;
   assign result = psum_nx;
`endif

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (cnt == CW'(WIDTH - 1)) begin
               last     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign psum_nx = mplier[0] ? (psum + mcand) : psum;

   // The cycle right after acceptance is not reported busy; busy covers steps 1..WIDTH-1.
   assign busy = (state == RUN) && (cnt != '0);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         psum   <= '0;
         mplier <= '0;
         cnt    <= '0;
         done   <= 1'b0;
         P      <= '0;
      end else begin
         done <= last;
         if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            psum   <= '0;
            cnt    <= '0;
         end else if (state == RUN) begin
            psum   <= psum_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last)
               P <= result;
         end
      end
   end

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult: table of products plus hand-written multi-cycle sequences.
// Build with SEQ_MULT_SIGNED_EN defined to exercise the two's-complement table.
module tb_seq_mult;

   localparam int WIDTH = 8;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [WIDTH-1:0]     a = '0;
   logic [WIDTH-1:0]     b = '0;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   P;

   int n_vec  = 0;
   int n_fail = 0;

   logic [2*WIDTH-1:0] prev_p = '0;

   typedef struct {
      logic [WIDTH-1:0]   a;
      logic [WIDTH-1:0]   b;
      logic [2*WIDTH-1:0] p;
   } vec_t;

   vec_t vecs[8];

   seq_mult #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .P     (P)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for done, returning edges elapsed (0 when the bound expires) and busy-high samples seen.
   task automatic wait_done(output int lat, output int nbusy, output bit p_held);
      lat    = 0;
      nbusy  = 0;
      p_held = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (done) begin
            lat = i;
            break;
         end
         if (busy) nbusy++;
         if (P !== prev_p) p_held = 1'b0;
      end
   endtask

   // Full transaction from an idle, post-edge point: accept, run, check product and pulse shape.
   task automatic do_mult(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic [2*WIDTH-1:0] exp_p);
      int lat, nbusy;
      bit p_held;
      a     = va;
      b     = vb;
      start = 1'b1;
      tick();
      start = 1'b0;
      a     = ~va;
      b     = ~vb;
      check({name, " busy after accept"}, busy, 1'b0);
      wait_done(lat, nbusy, p_held);
      check({name, " latency"}, lat, WIDTH);
      check({name, " busy cycles"}, nbusy, WIDTH - 1);
      check({name, " P held while running"}, p_held, 1'b1);
      check({name, " P"}, P, exp_p);
      check({name, " busy in done cycle"}, busy, 1'b0);
      prev_p = exp_p;
      tick();
      check({name, " done one cycle"}, done, 1'b0);
      check({name, " P held after"}, P, exp_p);
   endtask

   initial begin
      int lat, nbusy, ndone;
      bit p_held;

`ifdef SEQ_MULT_SIGNED_EN
      vecs[0] = '{8'd3,   8'd5,   16'h000F};
      vecs[1] = '{8'hFD,  8'd5,   16'hFFF1};
      vecs[2] = '{8'h80,  8'h80,  16'h4000};
      vecs[3] = '{8'd127, 8'hFF,  16'hFF81};
      vecs[4] = '{8'hFF,  8'hFF,  16'h0001};
      vecs[5] = '{8'd0,   8'hFB,  16'h0000};
      vecs[6] = '{8'h80,  8'd1,   16'hFF80};
      vecs[7] = '{8'd12,  8'hF4,  16'hFF70};
`else
      vecs[0] = '{8'd3,   8'd5,   16'h000F};
      vecs[1] = '{8'd255, 8'd255, 16'hFE01};
      vecs[2] = '{8'd0,   8'hAB,  16'h0000};
      vecs[3] = '{8'd0,   8'd7,   16'h0000};
      vecs[4] = '{8'hFF,  8'd1,   16'h00FF};
      vecs[5] = '{8'h80,  8'd2,   16'h0100};
      vecs[6] = '{8'd12,  8'd12,  16'h0090};
      vecs[7] = '{8'd1,   8'hFF,  16'h00FF};
`endif

      // Reset state
      #2;
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset P", P, 16'h0000);
      tick();
      rst = 1'b0;
      tick();
      check("idle hold done", done, 1'b0);

      // Table-driven products; entries 2 and 3 repeat a zero result and must still pulse done.
      for (int i = 0; i < 8; i++)
         do_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);

      // Start while busy is ignored, then back-to-back start in the done cycle.
      a = 8'd2; b = 8'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      a = 8'd9; b = 8'd9; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(lat, nbusy, p_held);
      check("busy-start latency", lat, WIDTH - 3);
      check("busy-start P", P, 16'd6);
      prev_p = 16'd6;
      a = 8'd4; b = 8'd4; start = 1'b1;
      tick();
      start = 1'b0;
      check("b2b done dropped", done, 1'b0);
      wait_done(lat, nbusy, p_held);
      check("b2b spacing", lat + 1, WIDTH + 1);
      check("b2b P held", p_held, 1'b1);
      check("b2b P", P, 16'd16);
      prev_p = 16'd16;
      tick();

      // Reset mid-operation aborts with no done pulse.
      a = 8'd10; b = 8'd10; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      #1;
      check("abort busy", busy, 1'b0);
      check("abort done", done, 1'b0);
      check("abort P", P, 16'h0000);
      tick();
      rst = 1'b0;
      prev_p = '0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) ndone++;
      end
      check("abort no done", ndone, 0);
      check("abort P held", P, 16'h0000);
      do_mult("after reset", 8'd1, 8'd1, 16'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
